// File: rtl/mp3_bus_arbiter.sv
// mp3_bus_arbiter: arbitrates SCI command and SDI data requesters onto the decoder serial bus.
// Define ARB_FAIR_EN for round-robin arbitration; otherwise commands have strict priority.
module mp3_bus_arbiter #(
    parameter int SCK_DIV = 5,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_DREQ,
    input  logic        i_cmd_req,
    input  logic [31:0] i_cmd_word,
    output logic        o_cmd_ack,
    input  logic        i_dat_req,
    input  logic [15:0] i_dat_word,
    output logic        o_dat_ack,
    output logic        o_XCS,
    output logic        o_XDCS,
    output logic        o_SCK,
    output logic        o_SI,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, CMD_SHIFT, DAT_SHIFT, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [31:0] sh_q, sh_d;
    logic        idle_go, grant_cmd, grant_dat, shifting;
    logic [4:0]  last_bit;

    assign idle_go = (state_q == IDLE) && i_DREQ && rst_n;

`ifdef ARB_FAIR_EN
    logic last_cmd_q;

    always_ff @(posedge clk)
        if (!rst_n) last_cmd_q <= 1'b0;
        else if (grant_cmd || grant_dat) last_cmd_q <= grant_cmd;

    assign grant_cmd = idle_go && i_cmd_req && !(i_dat_req && last_cmd_q);
`else
    assign grant_cmd = idle_go && i_cmd_req;
`endif
    assign grant_dat = idle_go && i_dat_req && !grant_cmd;

    assign last_bit = (state_q == CMD_SHIFT) ? 5'd31 : 5'd15;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE:
                if (grant_cmd || grant_dat) begin
                    state_d = grant_cmd ? CMD_SHIFT : DAT_SHIFT;
                    sh_d    = grant_cmd ? i_cmd_word : {i_dat_word, 16'h0000};
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            CMD_SHIFT, DAT_SHIFT:
                if (div_q == 8'(SCK_DIV - 1)) begin
                    div_d   = '0;
                    phase_d = !phase_q;
                    // the next bit is presented as the high phase ends, i.e. at the start of its low phase
                    if (phase_q) begin
                        if (bit_q == last_bit) begin
                            state_d = GAP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                            sh_d  = {sh_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            GAP:
                if (div_q == 8'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
        endcase
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
        end

    assign o_XCS     = state_q != CMD_SHIFT;
    assign o_XDCS    = state_q != DAT_SHIFT;
    assign shifting  = !o_XCS || !o_XDCS;
    assign o_SCK     = shifting && phase_q;
    assign o_SI      = shifting && sh_q[31];
    assign o_busy    = state_q != IDLE;
    assign o_cmd_ack = grant_cmd;
    assign o_dat_ack = grant_dat;
endmodule

// File: tb/tb_mp3_bus_arbiter.sv
// tb_mp3_bus_arbiter: directed and random stimulus against a timeline model of the serial bus.
module tb_mp3_bus_arbiter;
    localparam int D = 2;
    localparam int G = 2;

    logic        clk = 1'b0, rst_n = 1'b0, i_DREQ = 1'b0;
    logic        i_cmd_req = 1'b0, i_dat_req = 1'b0;
    logic [31:0] i_cmd_word = '0;
    logic [15:0] i_dat_word = '0;
    logic        o_cmd_ack, o_dat_ack, o_XCS, o_XDCS, o_SCK, o_SI, o_busy;

    int          checks = 0, errs = 0, cyc = 0;
    int          m_mode = 0, m_e = 0;
    logic [31:0] m_word = '0;
    bit          m_last_cmd = 1'b0, cmd_taken = 1'b0, dat_taken = 1'b0, prev_sck = 1'b0;
    int          sck_edges = 0;
    logic [31:0] si_bits = '0;
    int          glog[$];

    mp3_bus_arbiter #(.SCK_DIV(D), .GAP_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .i_DREQ(i_DREQ),
        .i_cmd_req(i_cmd_req), .i_cmd_word(i_cmd_word), .o_cmd_ack(o_cmd_ack),
        .i_dat_req(i_dat_req), .i_dat_word(i_dat_word), .o_dat_ack(o_dat_ack),
        .o_XCS(o_XCS), .o_XDCS(o_XDCS), .o_SCK(o_SCK), .o_SI(o_SI), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(input bit cmd, input string name);
        int t = 0;
        #1;
        while (!(cmd ? o_cmd_ack : o_dat_ack) && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(name, cmd ? o_cmd_ack : o_dat_ack, 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (o_busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, o_busy, 0);
    endtask

    // Model: a word is a timeline of elapsed cycles since the grant; SCK/SI follow by division.
    always @(negedge clk) begin
        int nb, len, bitn;
        bit e_sck, e_si, gc, gd;
        #2;
        if (cyc > 0) begin
            nb    = (m_mode == 1) ? 32 : 16;
            len   = nb * 2 * D;
            e_sck = 1'b0;
            e_si  = 1'b0;
            if (m_mode == 1 || m_mode == 2) begin
                bitn  = m_e / (2 * D);
                e_sck = ((m_e / D) % 2) == 1;
                e_si  = m_word[nb - 1 - bitn];
            end
            gc = 1'b0;
            gd = 1'b0;
            if (m_mode == 0 && rst_n && i_DREQ) begin
`ifdef ARB_FAIR_EN
                gc = i_cmd_req && !(i_dat_req && m_last_cmd);
`else
                gc = i_cmd_req;
`endif
                gd = i_dat_req && !gc;
            end
            chk("outputs", {o_cmd_ack, o_dat_ack, o_XCS, o_XDCS, o_SCK, o_SI, o_busy},
                {gc, gd, m_mode != 1, m_mode != 2, e_sck, e_si, m_mode != 0});
            if (o_cmd_ack) glog.push_back(1);
            if (o_dat_ack) glog.push_back(2);
            if (o_SCK && !prev_sck) begin
                sck_edges++;
                si_bits = {si_bits[30:0], o_SI};
            end
            prev_sck = o_SCK;
            if (!rst_n) begin
                m_mode     = 0;
                m_e        = 0;
                m_last_cmd = 1'b0;
            end else if (m_mode == 0) begin
                if (gc || gd) begin
                    m_mode     = gc ? 1 : 2;
                    m_e        = 0;
                    m_word     = gc ? i_cmd_word : {16'h0000, i_dat_word};
                    m_last_cmd = gc;
                end
            end else if (m_mode == 3) begin
                if (m_e == G - 1) begin m_mode = 0; m_e = 0; end else m_e++;
            end else begin
                if (m_e == len - 1) begin m_mode = 3; m_e = 0; end else m_e++;
            end
            cmd_taken = gc;
            dat_taken = gd;
        end
    end

    initial begin
        int code, bad, low, acks;
        logic [31:0] w5;
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        i_DREQ     = 1'b1;
        i_cmd_word = 32'h020B1234;
        i_cmd_req  = 1'b1;
        wait_ack(1, "t1_grant");
        sck_edges = 0;
        si_bits   = '0;
        for (int k = 1; k <= 131; k++) begin
            @(negedge clk);
            if (k == 1) i_cmd_req = 1'b0;
            if (k == 1) chk("t1_xcs_first", o_XCS, 0);
            if (k == 128) chk("t1_xcs_last", o_XCS, 0);
            if (k == 129) chk("t1_xcs_rise", o_XCS, 1);
            if (k == 130) chk("t1_busy_gap", o_busy, 1);
            if (k == 131) chk("t1_busy_idle", o_busy, 0);
        end
        chk("t1_sck_edges", sck_edges, 32);
        chk("t1_si_word", si_bits, 32'h020B1234);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        glog.delete();
        i_cmd_word = 32'hC0DE0001;
        i_dat_word = 16'hDA7A;
        i_cmd_req  = 1'b1;
        i_dat_req  = 1'b1;
        for (int t = 0; t < 2000 && glog.size() < 4; t++) begin
            @(negedge clk);
`ifndef ARB_FAIR_EN
            if (glog.size() == 3) i_cmd_req = 1'b0;
`endif
        end
        i_cmd_req = 1'b0;
        i_dat_req = 1'b0;
        code = 0;
        foreach (glog[i]) if (i < 4) code = code * 10 + glog[i];
`ifdef ARB_FAIR_EN
        chk("t2_grant_order", code, 1212);
`else
        chk("t2_grant_order", code, 1112);
`endif
        wait_idle("t2_idle");

        @(negedge clk);
        i_DREQ     = 1'b0;
        i_dat_req  = 1'b1;
        i_dat_word = 16'h3C5A;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_dat_ack || o_cmd_ack || !o_XDCS || o_SCK) bad++;
        end
        chk("t3_gated", bad, 0);
        i_DREQ = 1'b1;
        #1;
        chk("t3_ack", o_dat_ack, 1);
        @(negedge clk);
        chk("t3_xdcs_low", o_XDCS, 0);
        i_dat_req = 1'b0;
        wait_idle("t3_idle");

        @(negedge clk);
        i_dat_word = 16'hA55A;
        i_dat_req  = 1'b1;
        wait_ack(0, "t4_grant");
        sck_edges = 0;
        si_bits   = '0;
        low  = 0;
        acks = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) i_dat_req = 1'b0;
            if (k == 17) begin
                i_DREQ     = 1'b0;
                i_dat_req  = 1'b1;
                i_dat_word = 16'h1111;
            end
            if (!o_XDCS) low++;
            if (o_dat_ack || o_cmd_ack) acks++;
        end
        chk("t4_xdcs_len", low, 64);
        chk("t4_sck_edges", sck_edges, 16);
        chk("t4_si_word", si_bits, 32'h0000A55A);
        chk("t4_no_grant", acks, 0);
        i_DREQ = 1'b1;
        #1;
        chk("t4_regrant", o_dat_ack, 1);
        @(negedge clk);
        i_dat_req = 1'b0;
        wait_idle("t4_idle");

        @(negedge clk);
        w5         = $urandom;
        i_cmd_word = w5;
        i_cmd_req  = 1'b1;
        wait_ack(1, "t5_grant");
        repeat (42) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_reset", {o_XCS, o_SCK, o_busy, o_cmd_ack, o_dat_ack}, 5'b10000);
        rst_n = 1'b1;
        wait_ack(1, "t5_regrant");
        sck_edges = 0;
        si_bits   = '0;
        for (int k = 1; k <= 131; k++) begin
            @(negedge clk);
            if (k == 1) i_cmd_req = 1'b0;
        end
        chk("t5_sck_edges", sck_edges, 32);
        chk("t5_si_word", si_bits, w5);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            i_DREQ = $urandom_range(0, 3) != 0;
            if (cmd_taken) begin
                i_cmd_req  = $urandom_range(0, 1) == 1;
                i_cmd_word = $urandom;
            end else if (!i_cmd_req && $urandom_range(0, 7) == 0) begin
                i_cmd_req  = 1'b1;
                i_cmd_word = $urandom;
            end
            if (dat_taken) begin
                i_dat_req  = $urandom_range(0, 1) == 1;
                i_dat_word = 16'($urandom);
            end else if (!i_dat_req && $urandom_range(0, 3) == 0) begin
                i_dat_req  = 1'b1;
                i_dat_word = 16'($urandom);
            end
            rst_n = $urandom_range(0, 499) != 0;
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule

// File: doc/mp3_bus_arbiter.md
MP3_BUS_ARBITER -- requirements
Module: mp3_bus_arbiter

Interface
REQ-001 SHALL have parameter SCK_DIV, default 5: number of clk cycles per SCK half-period; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYC, default 2: number of clk cycles with both selects high after every word; legal range 1..255.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_DREQ  input  1  decoder ready; high means a word may start.
REQ-006 i_cmd_req  input  1  SCI requester has a command pending.
REQ-007 i_cmd_word  input  32  SCI command (opcode, address, data), held stable while i_cmd_req is high.
REQ-008 o_cmd_ack  output  1  one-cycle pulse: i_cmd_word latched.
REQ-009 i_dat_req  input  1  SDI requester has a data word pending.
REQ-010 i_dat_word  input  16  SDI data word, held stable while i_dat_req is high.
REQ-011 o_dat_ack  output  1  one-cycle pulse: i_dat_word latched.
REQ-012 o_XCS / o_XDCS / o_SCK / o_SI  output  1 each  serial bus to decoder.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, CMD_SHIFT, DAT_SHIFT and GAP.
REQ-015 In IDLE with i_DREQ=1, the arbiter SHALL grant one pending requester:
- latch its word;
- pulse its ack in that same cycle;
- enter the matching SHIFT state on the next edge.
REQ-016 In IDLE with i_DREQ=0, no grant and no ack SHALL occur; outputs remain idle.
REQ-017 If both requests are pending at grant time, the command SHALL win (strict priority) unless REQ-030 applies.
REQ-018 From the cycle after the grant, o_XCS (command) or o_XDCS (data) SHALL be 0 for 64*SCK_DIV (command) or 32*SCK_DIV (data) cycles. The other select SHALL stay 1.
REQ-019 Each bit SHALL be:
- SCK low for SCK_DIV cycles, with o_SI driven at the start of the low phase;
- then SCK high for SCK_DIV cycles.
Bits go out MSB first; the decoder samples on the rising SCK edge.
REQ-020 After the last high phase, SCK SHALL be 0, the select SHALL return to 1, and the state SHALL move to GAP.
REQ-021 GAP SHALL last GAP_CYC cycles, then go to IDLE. A new grant is possible in the first IDLE cycle.
REQ-022 i_DREQ falling during a SHIFT state SHALL NOT stall or abort the word; it only gates the next grant.
REQ-023 A requester dropping its req after the grant SHALL NOT affect the word in flight.
REQ-024 o_cmd_ack and o_dat_ack SHALL never be high in the same cycle, and each SHALL be at most one cycle wide per grant.
REQ-025 The bit counter and the SCK_DIV divider SHALL be internal counters. They reset to 0 on grant and never wrap mid-word.

Reset
REQ-026 With rst_n=0 at a clk edge, the next state SHALL be:
- state IDLE;
- o_XCS=1, o_XDCS=1, o_SCK=0, o_SI=0;
- o_cmd_ack=0, o_dat_ack=0, o_busy=0;
- all counters 0; latched words cleared.
REQ-027 Reset asserted mid-word SHALL abort the word at the next edge with no ack and no further SCK edges. After release, the first grant SHALL follow the normal IDLE rules.
REQ-028 Reset SHALL take priority over every other condition in the same cycle.

Configuration
REQ-029 Macro ARB_FAIR_EN SHALL select the arbitration policy.
REQ-030 With ARB_FAIR_EN defined, when both requests are pending the arbiter SHALL grant the requester not served by the previous grant (round-robin; the command wins first after reset).
REQ-031 Without ARB_FAIR_EN, strict command priority (REQ-017) SHALL apply always, and no last-grant register shall exist.

Verification (SCK_DIV=2, GAP_CYC=2)
REQ-032 Single command:
- stimulus: i_DREQ=1, i_cmd_req=1 with word 0x020B1234;
- response: o_cmd_ack pulses in grant cycle T; o_XCS=0 for cycles T+1..T+128; exactly 32 rising SCK edges; SI samples equal 0x020B1234 MSB first; o_XCS=1 at T+129; o_busy=0 at T+131.
REQ-033 Simultaneous requests:
- stimulus: command and data requests held continuously;
- without ARB_FAIR_EN: all command words complete before the first o_dat_ack;
- with ARB_FAIR_EN: grants alternate C, D, C, D.
REQ-034 DREQ gating:
- stimulus: i_DREQ=0 with i_dat_req=1 for 50 cycles;
- response: no ack, o_XDCS=1, o_SCK=0; after i_DREQ goes to 1, o_dat_ack occurs on the next edge.
REQ-035 DREQ drop mid-word:
- stimulus: data word 0xA55A; i_DREQ falls after the 4th bit;
- response: all 16 bits are shifted with o_XDCS held 0 for 64 cycles, then no new grant until i_DREQ=1.
REQ-036 Reset mid-command:
- stimulus: rst_n=0 at bit 10 of a command;
- response: next edge o_XCS=1, o_SCK=0, o_busy=0, no acks; after release, the pending command is re-granted from its MSB.
